// File: rtl/spi_slave.sv
// ============================================================================
// Module   : spi_slave
// Purpose  : 16-bit SPI slave (SCLK idle low). Captures MOSI on the falling
//            edge of SCLK and shifts MISO out MSB first. All master-side
//            inputs are asynchronous to clk and are resynchronised inside.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk      in   1   system clock, all logic on posedge
//   rst_n    in   1   synchronous active-low reset
//   SS_n     in   1   slave select (async, active low)
//   SCLK     in   1   SPI clock (async, idle low, period >= 8 clk)
//   MOSI     in   1   serial data from master (async, MSB first)
//   MISO     out  1   serial data to master, MSB first
//   tx_data  in   16  response word, captured when the frame starts
//   rx_data  out  16  last complete word received
//   rdy      out  1   one-clk pulse, rx_data just updated
// ----------------------------------------------------------------------------
// Build option
//   SPI_SLAVE_TRISTATE_EN : when defined, MISO floats (1'bz) while the
//                           synchronised SS_n is high and during reset.
//                           When undefined, MISO is driven 0 while not
//                           selected.
// ============================================================================
`default_nettype none

module spi_slave (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [15:0] tx_data,
  output logic [15:0] rx_data,
  output logic        rdy
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] SHIFT      = 2'd1;
  localparam logic [1:0] WAIT_DESEL = 2'd2;

  localparam logic [3:0] LAST_BIT   = 4'd15;
  localparam logic [1:0] FLUSH_DONE = 2'd3;

  // --------------------------------------------------------------------------
  // Input synchronisers: two flops for metastability plus one history flop.
  // All three inputs use the same depth so MOSI stays aligned with SCLK.
  // --------------------------------------------------------------------------
  logic ss_meta,   ss_sync,   ss_hist;
  logic sclk_meta, sclk_sync, sclk_hist;
  logic mosi_meta, mosi_sync, mosi_hist;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ss_meta   <= 1'b1;
      ss_sync   <= 1'b1;
      ss_hist   <= 1'b1;
      sclk_meta <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_hist <= 1'b0;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
      mosi_hist <= 1'b0;
    end else begin
      ss_meta   <= SS_n;
      ss_sync   <= ss_meta;
      ss_hist   <= ss_sync;
      sclk_meta <= SCLK;
      sclk_sync <= sclk_meta;
      sclk_hist <= sclk_sync;
      mosi_meta <= MOSI;
      mosi_sync <= mosi_meta;
      mosi_hist <= mosi_sync;
    end
  end

  // --------------------------------------------------------------------------
  // The synchronisers reset to "deselected". If SS_n is actually low when
  // reset is released, the reset value draining out of the chain would look
  // like a genuine SS_n fall and start a frame half way through. Edges are
  // only trusted once the chain has been refilled from the real pins.
  // --------------------------------------------------------------------------
  logic [1:0] flush_cnt;
  logic       sync_live;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flush_cnt <= 2'd0;
    end else if (flush_cnt != FLUSH_DONE) begin
      flush_cnt <= flush_cnt + 2'd1;
    end
  end

  assign sync_live = (flush_cnt == FLUSH_DONE);

  logic ss_fall;
  logic ss_rise;
  logic sclk_fall;

  assign ss_fall   = sync_live &  ss_hist & ~ss_sync;
  assign ss_rise   = sync_live & ~ss_hist &  ss_sync;
  assign sclk_fall = sclk_hist & ~sclk_sync;

  // --------------------------------------------------------------------------
  // Frame state machine and shift registers
  // --------------------------------------------------------------------------
  logic [1:0]  state;
  logic [3:0]  bit_cnt;
  logic [15:0] rx_shift;
  logic [15:0] tx_shift;
  logic [15:0] rx_next;

  // Word as it stands once the current MOSI bit is appended.
  assign rx_next = {rx_shift[14:0], mosi_sync};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= 4'd0;
      rx_shift <= 16'h0000;
      tx_shift <= 16'h0000;
      rx_data  <= 16'h0000;
      rdy      <= 1'b0;
    end else begin
      rdy <= 1'b0;
      case (state)
        IDLE: begin
          // A coincident SCLK fall is deliberately not counted here: the
          // frame only begins with the first fall seen in SHIFT.
          if (ss_fall) begin
            state    <= SHIFT;
            tx_shift <= tx_data;
            bit_cnt  <= 4'd0;
          end
        end

        SHIFT: begin
          if (ss_rise) begin
            // Master gave up early: drop the partial word silently.
            state <= IDLE;
          end else if (sclk_fall) begin
            rx_shift <= rx_next;
            tx_shift <= {tx_shift[14:0], 1'b0};
            bit_cnt  <= bit_cnt + 4'd1;
            if (bit_cnt == LAST_BIT) begin
              rx_data <= rx_next;
              rdy     <= 1'b1;
              state   <= WAIT_DESEL;
            end
          end
        end

        WAIT_DESEL: begin
          // Extra SCLK edges are ignored until the master deselects; the
          // shift registers are frozen so MISO holds.
          if (ss_rise) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // MISO drive. Gating on state keeps stale shift-register contents (for
  // example after an aborted frame) off the line before a new frame loads.
  // --------------------------------------------------------------------------
  logic selected;

  assign selected = ~ss_sync & (state != IDLE);

`ifdef SPI_SLAVE_TRISTATE_EN
  assign MISO = (!rst_n || ss_sync) ? 1'bz : (selected ? tx_shift[15] : 1'b0);
`else
  assign MISO = selected ? tx_shift[15] : 1'b0;
`endif

  // History flop on MOSI exists only to keep all three chains the same
  // depth; its value is not otherwise needed.
  logic unused_ok;
  assign unused_ok = mosi_hist;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave.sv
// ============================================================================
// Module   : tb_spi_slave
// Purpose  : Self-checking bench for spi_slave. A bit-banged SPI master
//            drives frames; expected received words go into a queue that a
//            separate monitor pops on every rdy pulse.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spi_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ss_n;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic [15:0] tx_data;
  logic [15:0] rx_data;
  logic        rdy;

  always #5 clk = ~clk;

  spi_slave dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .SS_n    (ss_n),
    .SCLK    (sclk),
    .MOSI    (mosi),
    .MISO    (miso),
    .tx_data (tx_data),
    .rx_data (rx_data),
    .rdy     (rdy)
  );

`ifdef SPI_SLAVE_TRISTATE_EN
  localparam logic IDLE_MISO = 1'bz;
`else
  localparam logic IDLE_MISO = 1'b0;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] last_rx;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every rdy cycle must match the oldest queued word.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rdy !== 1'b0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rdy: got rdy=%b rx_data=%h expected no rdy (t=%0t)",
                 rdy, rx_data, $time);
      end else begin
        chk("rdy_rx_data", rx_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Bit-banged master, SCLK idle low. MOSI is set up while SCLK is low,
  // MISO is sampled on the rising edge, the slave captures on the fall.
  task automatic frame(input logic [15:0] w, input int nbits, input int rst_at,
                       input int chg_at, input logic [15:0] chg_val,
                       input bit pre_high, output logic [15:0] got);
    got = 16'h0000;
    if (pre_high) begin
      sclk = 1'b1;
      repeat (6) @(negedge clk);
    end
    ss_n = 1'b0;
    sclk = 1'b0;
    repeat (5) @(negedge clk);
    for (int k = 0; k < nbits; k++) begin
      if (k == rst_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        chk("miso_in_reset", {15'b0, miso}, {15'b0, IDLE_MISO});
        @(negedge clk);
        rst_n = 1'b1;
      end
      if (k == chg_at) tx_data = chg_val;
      mosi = w[15-k];
      repeat (2) @(negedge clk);
      sclk = 1'b1;
      got  = {got[14:0], miso};
      repeat (5) @(negedge clk);
      sclk = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    ss_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic run_full(input logic [15:0] w, input logic [15:0] tx, input int chg_at,
                          input bit pre_high, input string tag);
    logic [15:0] got;
    tx_data = tx;
    exp_q.push_back(w);
    frame(w, 16, -1, chg_at, 16'hFFFF, pre_high, got);
    last_rx = w;
    chk({tag, "_miso_word"}, got, tx);
    chk({tag, "_rx_data"}, rx_data, last_rx);
    chk({tag, "_miso_idle"}, {15'b0, miso}, {15'b0, IDLE_MISO});
  endtask

  task automatic run_abort(input logic [15:0] w, input logic [15:0] tx, input int n,
                           input string tag);
    logic [15:0] got;
    tx_data = tx;
    frame(w, n, -1, -1, 16'h0000, 1'b0, got);
    chk({tag, "_miso_partial"}, got, tx >> (16 - n));
    chk({tag, "_rx_kept"}, rx_data, last_rx);
    chk({tag, "_miso_idle"}, {15'b0, miso}, {15'b0, IDLE_MISO});
  endtask

  initial begin
    logic [15:0] got;
    logic [15:0] w;
    logic [15:0] tx;
    int          n;

    rst_n   = 1'b0;
    ss_n    = 1'b1;
    sclk    = 1'b0;
    mosi    = 1'b0;
    tx_data = 16'h0000;
    last_rx = 16'h0000;
    repeat (3) @(negedge clk);
    chk("reset_rx_data", rx_data, 16'h0000);
    chk("reset_rdy", {15'b0, rdy}, 16'h0000);
    chk("reset_miso", {15'b0, miso}, {15'b0, IDLE_MISO});
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_miso", {15'b0, miso}, {15'b0, IDLE_MISO});

    // Basic exchange.
    run_full(16'hA5C3, 16'h1234, -1, 1'b0, "basic");

    // Abort after 9 falls, then a clean frame.
    run_abort(16'hBEEF, 16'hCAFE, 9, "abort9");
    run_full(16'h0F0F, 16'h3C3C, -1, 1'b0, "after_abort");

    // Back-to-back frames with extreme patterns.
    run_full(16'hFFFF, 16'h8000, -1, 1'b0, "b2b_1");
    run_full(16'h0001, 16'h7FFF, -1, 1'b0, "b2b_2");

    // Reset pulse after 5 bits while SS_n stays low: frame must vanish.
    tx_data = 16'h9999;
    frame(16'hDEAD, 16, 5, -1, 16'h0000, 1'b0, got);
    last_rx = 16'h0000;
    chk("midreset_rx_data", rx_data, last_rx);
    run_full(16'h5555, 16'hAAAA, -1, 1'b0, "post_reset");

    // tx_data changes after bit 3: MISO must still carry the captured word.
    run_full(16'h1357, 16'h1234, 4, 1'b0, "tx_change");

    // SS_n fall coincident with an SCLK fall: that edge is not a data bit.
    run_full(16'h2468, 16'hC001, -1, 1'b1, "coincident");

    // Randomised traffic with occasional aborts.
    for (int i = 0; i < 10; i++) begin
      w  = 16'($urandom);
      tx = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        n = $urandom_range(1, 15);
        run_abort(w, tx, n, "rand_abort");
      end else begin
        run_full(w, tx, -1, 1'b0, "rand_full");
      end
    end

    repeat (20) @(negedge clk);
    chk("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
